hub75_rx: RTL and testbench
===========================

Name: hub75_rx

Overview:
- Receiving end of the HUB75 LED-matrix link that the badge's matrix driver transmits on.
- Oversamples the HUB75 pins (r/g/b pairs, row address, shift clock, latch, OE) in the system clock domain and rebuilds each shifted line.
- On every latch, emits the line as a stream of pixel writes (valid/ready) for a framebuffer or checker.
- Used for panel chaining and as a loopback monitor of the driver.

Parameters:
- COLS, 5: pixels shifted per line (shift-clock pulses per latch).
- COL_W, 3: width of pix_col; must satisfy 2^COL_W >= COLS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- hub_r  in  2  red; bit0 = upper half, bit1 = lower half.
- hub_g  in  2  green, same split.
- hub_b  in  2  blue, same split.
- hub_row  in  4  row address.
- hub_clk  in  1  shift clock; data taken on its rising edge.
- hub_lat  in  1  latch; line ends on its rising edge.
- hub_oe  in  1  output enable.
- pix_valid  out  1  pixel write valid.
- pix_ready  in  1  sink accepts the beat when pix_valid & pix_ready.
- pix_half  out  1  0 = upper half, 1 = lower half.
- pix_row  out  4  row captured at latch.
- pix_col  out  COL_W  column index.
- pix_rgb  out  3  {r,g,b} for this pixel.
- disp_on  out  1  synchronized hub_oe.
- overrun  out  1  sticky: latch arrived while a burst was still emitting.
- short_line  out  1  sticky: latch arrived after fewer than COLS shift pulses.
- flag_clr  in  1  synchronous clear of overrun and short_line.

Behaviour:
- Reset (rst=0 at posedge):
  - Clears all synchronizer flops, the shift register, the hold buffer, the shift counter and all outputs; FSM goes to IDLE.
  - Reset mid-burst aborts the burst: pix_valid is low after that edge and stays low until a new latch.
- Synchronization:
  - Every hub_* input passes through 2 flops.
  - A third "prev" flop on hub_clk and hub_lat provides edge detection.
  - rise = sync2 & ~prev.
  - disp_on = sync2 of hub_oe.
- Shift:
  - On a hub_clk rise, shreg shifts by one: a new 6-bit {r1,g1,b1,r0,g0,b0} enters slot 0 and existing entries move toward slot COLS-1.
  - The shift counter increments, saturating at COLS.
  - Extra pulses beyond COLS push the oldest pixel out.
- Column mapping: after COLS pulses, slot k holds column k. The last-shifted pixel is column 0; the first-shifted pixel is column COLS-1.
- Latch (hub_lat rise):
  - If the FSM is IDLE: load hold with the post-shift shreg value (a hub_clk rise in the same cycle is applied first), capture row from hub_row sync2, then enter EMIT.
  - If the shift counter was < COLS: set short_line.
  - Shift counter returns to 0 on every latch rise. shreg itself is not cleared; unfilled slots keep stale data.
  - If the FSM is EMIT: set overrun. Hold and row are not modified, and the current burst continues unchanged.
- Latency: hub_lat is sampled high by sync1 at edge N; pix_valid is high after edge N+3.
- FSM:
  - IDLE: pix_valid = 0.
  - EMIT: pix_valid = 1; beat index i runs 0 .. 2*COLS-1.
    - half = (i >= COLS).
    - col = i mod COLS.
    - rgb is taken from hold slot col for that half.
  - The index advances only on valid & ready.
  - Payload is stable while valid & ~ready.
  - On acceptance of beat 2*COLS-1: next state IDLE, pix_valid low on the following cycle.
  - A latch in the same cycle as the final acceptance counts as overrun (the FSM is still in EMIT).
- Flags: flag_clr has priority over a set in the same cycle. Flags only clear via flag_clr or reset.
- Pixel outputs hold their last values in IDLE; only pix_valid is meaningful there.

Test Plan:
- Driver default pattern: 5 hub_clk pulses (each input held ≥3 clk per level) with r=g=b=2'b11, hub_row=0, then a latch; pix_ready=1.
  -> 10 beats, all pix_rgb=3'b111, row 0; half=0 with cols 0..4, then half=1 with cols 0..4.
  -> overrun=0, short_line=0.
- Column mapping: upper-half r over pulses 1..5 = 1,0,1,1,0; all other bits 0; latch with row=4'd9.
  -> Upper beats col0..col4 rgb = 000,100,100,000,100; lower beats all 000; pix_row=9.
- Backpressure: repeat the first test with pix_ready low for 3 cycles at beat 2 and again at beat 7.
  -> Payload frozen during the stalls; exactly 10 beats in order; none lost or duplicated.
- Overrun: with pix_ready=0 during a burst, drive 5 new pulses plus a latch.
  -> overrun=1; after ready returns, the original 10 beats complete with the original data and no second burst.
  -> flag_clr pulse -> overrun=0.
- Short line: 3 pulses then a latch.
  -> short_line=1; a burst of 10 beats is still emitted.
  -> Cols 0..2 carry the new data; cols 3..4 carry slots shifted from the previous line.
- Reset mid-burst: rst=0 for one cycle at beat 4.
  -> pix_valid=0 from the next cycle; all outputs 0; no further beats until a new latch.

Source files
------------

// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples the matrix pins in the clk domain, rebuilds each shifted line
// and replays it on latch as a valid/ready stream of pixel writes (upper half, then lower half).
module hub75_rx #(
    parameter int COLS  = 5,
    parameter int COL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hub_r,
    input  logic [1:0]       hub_g,
    input  logic [1:0]       hub_b,
    input  logic [3:0]       hub_row,
    input  logic             hub_clk,
    input  logic             hub_lat,
    input  logic             hub_oe,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_half,
    output logic [3:0]       pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic [2:0]       pix_rgb,
    output logic             disp_on,
    output logic             overrun,
    output logic             short_line,
    input  logic             flag_clr
);
    typedef logic [COL_W:0]   cnt_t;
    typedef logic [COL_W-1:0] col_t;
    typedef enum logic {IDLE, EMIT} state_t;

    localparam int   SW   = 6 * COLS;
    localparam cnt_t NCOL = cnt_t'(COLS);
    localparam cnt_t LAST = cnt_t'(2 * COLS - 1);

    // Packed pin bundle: [12]=oe [11]=lat [10]=clk [9:6]=row [5:0]={r1,g1,b1,r0,g0,b0}
    logic [12:0]   in_vec;
    logic [12:0]   s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    prev_q, prev_d;
    logic          clk_ev_q, clk_ev_d, lat_ev_q, lat_ev_d;
    logic [5:0]    px_q, px_d;
    logic [3:0]    row_ev_q, row_ev_d;
    logic [SW-1:0] shreg_q, shreg_d, hold_q, hold_d;
    cnt_t          cnt_q, cnt_d, idx_q, idx_d;
    logic [3:0]    row_q, row_d;
    state_t        state_q, state_d;
    logic          overrun_q, overrun_d, short_q, short_d;
    cnt_t          idx_col;
    logic [5:0]    slot;

    assign in_vec = {hub_oe, hub_lat, hub_clk, hub_row,
                     hub_r[1], hub_g[1], hub_b[1], hub_r[0], hub_g[0], hub_b[0]};

    always_comb begin
        s1_d     = in_vec;
        s2_d     = s1_q;
        prev_d   = s2_q[11:10];
        // Edge events are registered together with the data they qualify
        clk_ev_d = s2_q[10] & ~prev_q[0];
        lat_ev_d = s2_q[11] & ~prev_q[1];
        px_d     = s2_q[5:0];
        row_ev_d = s2_q[9:6];

        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        row_d     = row_q;
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        short_d   = short_q;

        if (clk_ev_q) begin
            shreg_d = {shreg_q[SW-7:0], px_q};
            if (cnt_q != NCOL) cnt_d = cnt_q + 1'b1;
        end

        if (state_q == EMIT && pix_ready) begin
            if (idx_q == LAST) state_d = IDLE;
            else               idx_d   = idx_q + 1'b1;
        end

        // A shift in the same cycle as the latch has already been folded into shreg_d/cnt_d
        if (lat_ev_q) begin
            if (cnt_d < NCOL) short_d = 1'b1;
            cnt_d = '0;
            if (state_q == IDLE) begin
                hold_d  = shreg_d;
                row_d   = row_ev_q;
                idx_d   = '0;
                state_d = EMIT;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (flag_clr) begin
            overrun_d = 1'b0;
            short_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            clk_ev_q  <= 1'b0;
            lat_ev_q  <= 1'b0;
            px_q      <= '0;
            row_ev_q  <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            row_q     <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            clk_ev_q  <= clk_ev_d;
            lat_ev_q  <= lat_ev_d;
            px_q      <= px_d;
            row_ev_q  <= row_ev_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            row_q     <= row_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            short_q   <= short_d;
        end
    end

    // idx is left on the last beat after a burst so the payload holds while idle
    always_comb begin
        pix_half = (idx_q >= NCOL);
        idx_col  = pix_half ? (idx_q - NCOL) : idx_q;
        pix_col  = idx_col[COL_W-1:0];
        slot     = '0;
        for (int k = 0; k < COLS; k++) begin
            if (pix_col == col_t'(k)) slot = hold_q[6*k +: 6];
        end
        pix_rgb  = pix_half ? slot[5:3] : slot[2:0];
    end

    assign pix_valid  = (state_q == EMIT);
    assign pix_row    = row_q;
    assign disp_on    = s2_q[12];
    assign overrun    = overrun_q;
    assign short_line = short_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: stimulus pushes hand-computed beats, a negedge monitor pops
// and compares every accepted beat and checks payload stability across stalls.
module tb_hub75_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] hub_r = '0, hub_g = '0, hub_b = '0;
    logic [3:0] hub_row = '0;
    logic       hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b0;
    logic       pix_valid, pix_ready = 1'b1;
    logic       pix_half;
    logic [3:0] pix_row;
    logic [2:0] pix_col;
    logic [2:0] pix_rgb;
    logic       disp_on, overrun, short_line;
    logic       flag_clr = 1'b0;

    int errors   = 0;
    int checks   = 0;
    int accepted = 0;

    logic [10:0] exp_q[$];
    logic [10:0] stall_pl;
    logic        stalled = 1'b0;

    hub75_rx #(.COLS(5), .COL_W(3)) dut (
        .clk(clk), .rst(rst),
        .hub_r(hub_r), .hub_g(hub_g), .hub_b(hub_b), .hub_row(hub_row),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_half(pix_half), .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
        .disp_on(disp_on), .overrun(overrun), .short_line(short_line),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    // Monitor: a beat is taken on the coming posedge when valid & ready at this negedge
    always @(negedge clk) begin
        logic [10:0] act, e;
        act = {pix_half, pix_row, pix_col, pix_rgb};
        if (rst && pix_valid) begin
            if (stalled) begin
                checks++;
                if (act !== stall_pl) begin
                    errors++;
                    $display("FAIL stall_hold: got %h, required %h", act, stall_pl);
                end
            end
            if (pix_ready) begin
                accepted++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h, required no beat", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL beat: got half=%0d row=%0d col=%0d rgb=%b, required half=%0d row=%0d col=%0d rgb=%b",
                                 act[10], act[9:6], act[5:3], act[2:0], e[10], e[9:6], e[5:3], e[2:0]);
                    end
                end
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                stall_pl = act;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_beat(input logic half, input logic [3:0] row, input logic [2:0] col,
                             input logic [2:0] rgb);
        exp_q.push_back({half, row, col, rgb});
    endtask

    // Column k of each half lives at bits [3k+:3]
    task automatic push_line(input logic [3:0] row, input logic [14:0] up, input logic [14:0] lo);
        for (int k = 0; k < 5; k++) push_beat(1'b0, row, 3'(k), up[3*k +: 3]);
        for (int k = 0; k < 5; k++) push_beat(1'b1, row, 3'(k), lo[3*k +: 3]);
    endtask

    task automatic pulse(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
        hub_r = r; hub_g = g; hub_b = b;
        hub_clk = 1'b1;
        tick(3);
        hub_clk = 1'b0;
        tick(3);
    endtask

    task automatic latch(input bit meas);
        int first;
        first = 0;
        hub_lat = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (first == 0 && pix_valid) first = k;
        end
        hub_lat = 1'b0;
        tick(4);
        if (meas) chk("latch_latency", first, 4);
    endtask

    task automatic wait_accept(input int target);
        for (int i = 0; i < 300; i++) begin
            if (accepted >= target) break;
            tick();
        end
        chk("wait_accept", (accepted >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        tick(3);
        chk("rst_valid", pix_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_short", short_line, 0);
        chk("rst_row", pix_row, 0);
        rst = 1'b1;
        tick(2);

        hub_oe = 1'b1;
        tick(3);
        chk("disp_on", disp_on, 1);

        // Default pattern, full speed
        for (int p = 0; p < 5; p++) pulse(2'b11, 2'b11, 2'b11);
        push_line(4'd0, {5{3'b111}}, {5{3'b111}});
        latch(1'b1);
        wait_drain();
        tick(3);
        chk("t1_overrun", overrun, 0);
        chk("t1_short", short_line, 0);
        chk("t1_idle", pix_valid, 0);

        // Column mapping: upper r over pulses = 1,0,1,1,0
        hub_row = 4'd9;
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b00, 2'b00, 2'b00);
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b00, 2'b00, 2'b00);
        push_line(4'd9, {3'b100, 3'b000, 3'b100, 3'b100, 3'b000}, 15'd0);
        latch(1'b1);
        wait_drain();
        tick(3);

        // Backpressure at beats 2 and 7
        hub_row = 4'd0;
        for (int p = 0; p < 5; p++) pulse(2'b11, 2'b11, 2'b11);
        pix_ready = 1'b0;
        base = accepted;
        push_line(4'd0, {5{3'b111}}, {5{3'b111}});
        latch(1'b0);
        pix_ready = 1'b1;
        wait_accept(base + 2);
        pix_ready = 1'b0;
        tick(3);
        pix_ready = 1'b1;
        wait_accept(base + 7);
        pix_ready = 1'b0;
        tick(3);
        pix_ready = 1'b1;
        wait_drain();
        tick(5);
        chk("t3_beats", accepted - base, 10);

        // Overrun: new line and latch while the first burst is stalled
        hub_row = 4'd9;
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b00, 2'b00, 2'b00);
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b01, 2'b00, 2'b00);
        pulse(2'b00, 2'b00, 2'b00);
        pix_ready = 1'b0;
        base = accepted;
        push_line(4'd9, {3'b100, 3'b000, 3'b100, 3'b100, 3'b000}, 15'd0);
        latch(1'b0);
        hub_row = 4'd3;
        for (int p = 0; p < 5; p++) pulse(2'b11, 2'b11, 2'b11);
        latch(1'b0);
        chk("t4_overrun_set", overrun, 1);
        chk("t4_short", short_line, 0);
        pix_ready = 1'b1;
        wait_drain();
        tick(20);
        chk("t4_beats", accepted - base, 10);
        chk("t4_overrun_sticky", overrun, 1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        tick();
        chk("t4_overrun_clr", overrun, 0);

        // Short line: 3 pulses over a shreg still full of 111
        hub_row = 4'd5;
        pulse(2'b00, 2'b01, 2'b00);
        pulse(2'b00, 2'b00, 2'b01);
        pulse(2'b10, 2'b00, 2'b00);
        push_line(4'd5, {3'b111, 3'b111, 3'b010, 3'b001, 3'b000},
                        {3'b111, 3'b111, 3'b000, 3'b000, 3'b100});
        latch(1'b0);
        chk("t5_short_set", short_line, 1);
        wait_drain();
        tick(3);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        tick();
        chk("t5_short_clr", short_line, 0);

        // Reset mid-burst at beat 4
        hub_row = 4'd2;
        for (int p = 0; p < 5; p++) pulse(2'b11, 2'b11, 2'b11);
        pix_ready = 1'b0;
        base = accepted;
        for (int k = 0; k < 4; k++) push_beat(1'b0, 4'd2, 3'(k), 3'b111);
        latch(1'b0);
        pix_ready = 1'b1;
        wait_accept(base + 4);
        pix_ready = 1'b0;
        rst = 1'b0;
        tick();
        chk("t6_valid", pix_valid, 0);
        chk("t6_payload", {pix_half, pix_row, pix_col, pix_rgb}, 0);
        chk("t6_disp_on", disp_on, 0);
        rst = 1'b1;
        pix_ready = 1'b1;
        tick(20);
        chk("t6_no_beats", accepted - base, 4);
        chk("t6_valid_after", pix_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
